// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU request scheduler.
//   OP_*     : opcodes understood by the downstream ALU (passed through untouched)
//   state_t  : scheduler FSM encoding
package alu_sched_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_OR  = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_SHL = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_ROL = 3'd6;
   localparam logic [2:0] OP_ROR = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index this round
//   gnt    : one-hot grant (all zero when no request)
//   gnt_id : index of the granted requester
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   // Scan from ptr upward, wrapping modulo NREQ; first hit wins.
   always_comb begin
      int unsigned idx;
      logic [IDW-1:0] idx_n;
      logic found;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_n = IDW'(idx);
         if (!found && req[idx_n]) begin
            found       = 1'b1;
            gnt[idx_n]  = 1'b1;
            gnt_id      = idx_n;
         end
      end
   end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one combinational ALU between NREQ requesters, one operation in flight.
// Optional feature macro: ALU_SCHED_OPCNT_EN adds op_count (completed responses).
//   clk, rst              : clock, async active-high reset
//   req_valid/a/b/sel     : packed per-requester requests (lane i at [i*W +: W])
//   req_ready             : one-hot accept, combinational, only in IDLE
//   alu_a/alu_b/alu_sel   : registered operands/opcode to the ALU
//   alu_r                 : combinational ALU result
//   rsp_valid/id/data     : registered, tagged response; rsp_ready completes it
//   op_count              : (macro only) 16-bit wrapping count of response handshakes
module alu_req_sched
   import alu_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   input  logic [NREQ*3-1:0] req_sel,
   output logic [NREQ-1:0]   req_ready,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [2:0]        alu_sel,
   input  logic [DW:0]       alu_r,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [DW:0]       rsp_data,
`ifdef ALU_SCHED_OPCNT_EN
   output logic [15:0]       op_count,
`endif
   input  logic              rsp_ready
);

   state_t          state, state_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  cur_id;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            accept;
   logic            rsp_done;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state and handshake decode; grant is suppressed while reset is held
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rst && (|gnt)) begin
               req_ready = gnt;
               accept    = 1'b1;
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: state_nxt = S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               rsp_done  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, result capture and round-robin pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         cur_id    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         if (accept) begin
            alu_a   <= req_a[32'(gnt_id)*DW +: DW];
            alu_b   <= req_b[32'(gnt_id)*DW +: DW];
            alu_sel <= req_sel[32'(gnt_id)*3 +: 3];
            cur_id  <= gnt_id;
         end
         if (state == S_EXEC) begin
            rsp_data  <= alu_r;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
         end
         if (rsp_done) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + IDW'(1);
         end
      end
   end

`ifdef ALU_SCHED_OPCNT_EN
   // Completed-response counter, wraps naturally at 16 bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           op_count <= '0;
      else if (rsp_done) op_count <= op_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_alu_req_sched.sv
// Self-checking bench for alu_req_sched (NREQ=4, DW=4): directed table, corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_alu_req_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_a, req_b;
   logic [11:0] req_sel;
   logic [3:0]  req_ready;
   logic [3:0]  alu_a, alu_b;
   logic [2:0]  alu_sel;
   logic [4:0]  alu_r;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [4:0]  rsp_data;
   logic        rsp_ready;
`ifdef ALU_SCHED_OPCNT_EN
   logic [15:0] op_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_req_sched #(.NREQ(4), .DW(4), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_r     (alu_r),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
`ifdef ALU_SCHED_OPCNT_EN
      .op_count  (op_count),
`endif
      .rsp_ready (rsp_ready)
   );

   // Behavioural ALU used both as the DUT's environment and for expectations
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s);
      case (s)
         3'd0:    return 5'(a) + 5'(b);
         3'd1:    return 5'(a) - 5'(b);
         3'd2:    return {1'b0, a | b};
         3'd3:    return {1'b0, a & b};
         3'd4:    return {a, 1'b0};
         3'd5:    return {2'b00, a[3:1]};
         3'd6:    return {1'b0, a[2:0], a[3]};
         default: return {1'b0, a[0], a[3:1]};
      endcase
   endfunction

   always_comb alu_r = alu_f(alu_a, alu_b, alu_sel);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_lane(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] s);
      req_a[i*4 +: 4]   = a;
      req_b[i*4 +: 4]   = b;
      req_sel[i*3 +: 3] = s;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drop requests, then expect one response two cycles after the grant and handshake it
   task automatic finish_op(input string nm, input logic [1:0] id, input logic [4:0] data);
      @(negedge clk); req_valid = '0; #1;
      chk({nm, "_exec_valid"}, rsp_valid, 0);
      chk({nm, "_exec_ready"}, req_ready, 0);
      @(negedge clk); rsp_ready = 1'b1; #1;
      chk({nm, "_rsp_valid"}, rsp_valid, 1);
      chk({nm, "_rsp_id"}, rsp_id, id);
      chk({nm, "_rsp_data"}, rsp_data, data);
      @(negedge clk); rsp_ready = 1'b0; #1;
      chk({nm, "_after_valid"}, rsp_valid, 0);
   endtask

   typedef struct {
      logic [3:0] valid;
      logic [3:0] a, b;
      logic [2:0] sel;
      logic [3:0] gnt;
      logic [1:0] id;
      logic [4:0] data;
   } vec_t;

   vec_t tbl [7];

   // Reference-model state for the random run
   int         m_stage, m_ptr, m_id, win;
   logic [4:0] m_data;
   logic [3:0] done_l;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;

      // Table applied in order; pointer progresses 0,1,2,0,2,3,1
      tbl[0] = '{4'b0001, 4'd9,  4'd8,  3'd0, 4'b0001, 2'd0, 5'h11};
      tbl[1] = '{4'b0010, 4'd2,  4'd3,  3'd1, 4'b0010, 2'd1, 5'h1F};
      tbl[2] = '{4'b1001, 4'd7,  4'd12, 3'd2, 4'b1000, 2'd3, 5'h0F};
      tbl[3] = '{4'b1110, 4'd6,  4'd5,  3'd3, 4'b0010, 2'd1, 5'h04};
      tbl[4] = '{4'b0101, 4'd15, 4'd1,  3'd0, 4'b0100, 2'd2, 5'h10};
      tbl[5] = '{4'b0001, 4'd0,  4'd1,  3'd1, 4'b0001, 2'd0, 5'h1F};
      tbl[6] = '{4'b0001, 4'd15, 4'd15, 3'd0, 4'b0001, 2'd0, 5'h1E};

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      req_valid = 4'b1111; #1;
      chk("rst_req_ready", req_ready, 0);
      req_valid = '0;
      @(negedge clk); rst = 1'b0;

      // All requesters held: grants 0,1,2,3,0 every third cycle
      for (int i = 0; i < 4; i++) set_lane(i, 4'(i), 4'd1, 3'd0);
      for (int c = 0; c < 15; c++) begin
         @(negedge clk); req_valid = 4'b1111; rsp_ready = 1'b1; #1;
         chk("rr_ready", req_ready, (c % 3 == 0) ? (32'd1 << ((c / 3) % 4)) : 32'd0);
         if (c % 3 == 2) begin
            chk("rr_rsp_valid", rsp_valid, 1);
            chk("rr_rsp_id", rsp_id, (c / 3) % 4);
            chk("rr_rsp_data", rsp_data, ((c / 3) % 4) + 1);
         end
      end
      req_valid = '0; rsp_ready = 1'b0;

      // Directed table, pointer back at 0
      do_reset();
      for (int v = 0; v < 7; v++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (i == int'(tbl[v].id)) set_lane(i, tbl[v].a, tbl[v].b, tbl[v].sel);
            else                      set_lane(i, ~tbl[v].a, ~tbl[v].b, ~tbl[v].sel);
         end
         req_valid = tbl[v].valid; rsp_ready = 1'b0; #1;
         chk("tbl_ready", req_ready, tbl[v].gnt);
         finish_op("tbl", tbl[v].id, tbl[v].data);
      end

      // Back-pressure: pointer 1, lane 2 wins, response held 5 cycles
      @(negedge clk);
      for (int i = 0; i < 4; i++) set_lane(i, 4'(i), 4'd8, 3'd2);
      set_lane(2, 4'd3, 4'd4, 3'd0);
      req_valid = 4'b0100; #1;
      chk("bp_ready", req_ready, 4'b0100);
      @(negedge clk); req_valid = '0; #1;
      chk("bp_exec_valid", rsp_valid, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); req_valid = 4'b1111; rsp_ready = 1'b0; #1;
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_id", rsp_id, 2);
         chk("bp_hold_data", rsp_data, 5'h07);
         chk("bp_hold_ready", req_ready, 0);
      end
      @(negedge clk); set_lane(2, 4'd2, 4'd8, 3'd2); rsp_ready = 1'b1; #1;
      chk("bp_hs_valid", rsp_valid, 1);
      chk("bp_hs_ready", req_ready, 0);
      @(negedge clk); rsp_ready = 1'b0; #1;
      chk("bp_next_grant", req_ready, 4'b1000);
      finish_op("bp_next", 2'd3, 5'h0B);

      // Reset during EXEC: op dropped, pointer back to 0
      @(negedge clk); set_lane(1, 4'd1, 4'd1, 3'd0); req_valid = 4'b0010; #1;
      chk("rx_pre_ready", req_ready, 4'b0010);
      finish_op("rx_pre", 2'd1, 5'h02);
      @(negedge clk); set_lane(2, 4'd5, 4'd5, 3'd0); req_valid = 4'b0100; #1;
      chk("rx_ready", req_ready, 4'b0100);
      @(negedge clk); req_valid = '0; #2; rst = 1'b1; #1;
      chk("rx_rsp_valid", rsp_valid, 0);
      chk("rx_rsp_id", rsp_id, 0);
      chk("rx_rsp_data", rsp_data, 0);
      chk("rx_alu_a", alu_a, 0);
      chk("rx_alu_b", alu_b, 0);
      chk("rx_alu_sel", alu_sel, 0);
      @(negedge clk); rst = 1'b0;
      repeat (2) begin
         @(negedge clk); #1;
         chk("rx_no_rsp", rsp_valid, 0);
      end
      for (int i = 0; i < 4; i++) set_lane(i, 4'(i), 4'd4, 3'd0);
      @(negedge clk); req_valid = 4'b1111; #1;
      chk("rx_ptr0_grant", req_ready, 4'b0001);
      finish_op("rx_post", 2'd0, 5'h04);

`ifdef ALU_SCHED_OPCNT_EN
      do_reset();
      #1 chk("cnt_rst", op_count, 0);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk); set_lane(0, 4'(n), 4'd0, 3'd0); req_valid = 4'b0001; #1;
         chk("cnt_ready", req_ready, 4'b0001);
         finish_op("cnt_op", 2'd0, 5'(n));
      end
      chk("cnt_ten", op_count, 10);
      @(negedge clk); rst = 1'b1; #1;
      chk("cnt_after_rst", op_count, 0);
      @(negedge clk); rst = 1'b0;
`endif

      // Randomized run against the transaction-level model
      do_reset();
      m_stage = 0; m_ptr = 0; m_id = 0; m_data = '0; done_l = '0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (done_l[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_valid[i] = 1'b1;
                  set_lane(i, 4'($urandom), 4'($urandom), 3'($urandom));
               end
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         done_l    = '0;
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         win = -1;
         if (m_stage == 0)
            for (int k = 3; k >= 0; k--)
               if (req_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
         chk("rnd_ready", req_ready, (win >= 0) ? (32'd1 << win) : 32'd0);
         chk("rnd_rsp_valid", rsp_valid, (m_stage == 2) ? 1 : 0);
         if (m_stage == 2) begin
            chk("rnd_rsp_id", rsp_id, m_id);
            chk("rnd_rsp_data", rsp_data, m_data);
         end
         if (m_stage == 0 && win >= 0) begin
            m_id      = win;
            m_data    = alu_f(req_a[win*4 +: 4], req_b[win*4 +: 4], req_sel[win*3 +: 3]);
            m_stage   = 1;
            done_l[win] = 1'b1;
         end else if (m_stage == 1) begin
            m_stage = 2;
         end else if (m_stage == 2 && rsp_ready) begin
            m_stage = 0;
            m_ptr   = (m_id + 1) % 4;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
